// File: rtl/oddrx2_tx_pkg.sv
// Shared types and constants for the ODDRX2E transmit gearbox.
package oddrx2_tx_pkg;

    localparam int WORD_W = 8;
    localparam int LANE_W = 4;

    // Training / idle word; its nibble-swap differs, so the far end can find word alignment.
    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 8'hA5;

    typedef enum logic {
        TRAIN = 1'b0,
        DATA  = 1'b1
    } tx_state_e;

endpackage : oddrx2_tx_pkg

// File: rtl/oddrx2_tx_gearbox.sv
// 8:4 transmit gearbox: turns a byte stream into nibbles for ODDRX2E D0..D3,
// with training bursts after reset / on request and SYNC_WORD idle fill.
module oddrx2_tx_gearbox
    import oddrx2_tx_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int                TRAIN_LEN  = 16,
    parameter int                IDLE_CNT_W = 16
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  train_start,
    output logic                  train_busy,
    output logic [LANE_W-1:0]     d_out,
    output logic                  idle_pulse,
    output logic [IDLE_CNT_W-1:0] idle_count
);

    // Boundary-load count at which the burst is complete (entry word + TRAIN_LEN-1 loads).
    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LEN - 2);

    logic                  phase_q,      phase_d;
    logic [WORD_W-1:0]     cur_word_q,   cur_word_d;
    logic [LANE_W-1:0]     d_out_q,      d_out_d;
    tx_state_e             state_q,      state_d;
    logic [7:0]            train_cnt_q,  train_cnt_d;
    logic                  train_pend_q, train_pend_d;
    logic                  idle_pulse_q, idle_pulse_d;
    logic [IDLE_CNT_W-1:0] idle_count_q, idle_count_d;

    // Next-state: nibble launch every edge, word reload only on the high-nibble (phase 1) edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        phase_d      = ~phase_q;
        d_out_d      = phase_q ? cur_word_q[WORD_W-1:LANE_W] : cur_word_q[LANE_W-1:0];
        cur_word_d   = cur_word_q;
        state_d      = state_q;
        train_cnt_d  = train_cnt_q;
        train_pend_d = train_pend_q;
        idle_pulse_d = 1'b0;
        idle_count_d = idle_count_q;

        // A request while sending data is remembered until the next boundary; in TRAIN it is dropped.
        if (state_q == DATA && train_start) begin
            train_pend_d = 1'b1;
        end

        if (phase_q) begin
            case (state_q)
                TRAIN: begin
                    cur_word_d = SYNC_WORD;
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d     = DATA;
                        train_cnt_d = '0;
                    end else begin
                        train_cnt_d = train_cnt_q + 8'd1;
                    end
                end
                DATA: begin
                    if (train_pend_q) begin
                        cur_word_d   = SYNC_WORD;
                        state_d      = TRAIN;
                        train_cnt_d  = '0;
                        train_pend_d = 1'b0;
                    end else if (in_valid) begin
                        cur_word_d = in_data;
                    end else begin
                        cur_word_d   = SYNC_WORD;
                        idle_pulse_d = 1'b1;
                        if (idle_count_q != '1) begin
                            idle_count_d = idle_count_q + IDLE_CNT_W'(1);
                        end
                    end
                end
                default: state_d = TRAIN;
            endcase
        end
    end

    // State register with synchronous active-low reset; reset abandons any partial word.
    always_ff @(posedge sclk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            phase_q      <= 1'b0;
            cur_word_q   <= SYNC_WORD;
            d_out_q      <= '0;
            state_q      <= TRAIN;
            train_cnt_q  <= '0;
            train_pend_q <= 1'b0;
            idle_pulse_q <= 1'b0;
            idle_count_q <= '0;
        end else begin
            phase_q      <= phase_d;
            cur_word_q   <= cur_word_d;
            d_out_q      <= d_out_d;
            state_q      <= state_d;
            train_cnt_q  <= train_cnt_d;
            train_pend_q <= train_pend_d;
            idle_pulse_q <= idle_pulse_d;
            idle_count_q <= idle_count_d;
        end
    end

    // Handshake and status are decoded from registers only.
    always_comb begin
        in_ready   = phase_q & (state_q == DATA) & ~train_pend_q;
        train_busy = (state_q == TRAIN) | train_pend_q;
        d_out      = d_out_q;
        idle_pulse = idle_pulse_q;
        idle_count = idle_count_q;
    end

endmodule : oddrx2_tx_gearbox
